// File: rtl/param_right_rotator_pipe_pkg.sv
// Shared constants and the rotate helper for the pipelined right rotator.
package rotator_pkg;

  localparam int unsigned N_DEFAULT = 3;
  localparam int unsigned MAX_N     = 8;
  localparam int unsigned MAX_W     = 1 << MAX_N;

  // Data width for a given log2 width.
  function automatic int unsigned word_width(input int unsigned n);
    return 1 << n;
  endfunction

  // Rotate the low w bits of data right by r; bits at and above w are don't-care.
  // Callers zero-extend into MAX_W and truncate the result back to w bits.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] data,
                                            input int unsigned       r,
                                            input int unsigned       w);
    return (data >> r) | (data << (w - r));
  endfunction

endpackage

// File: rtl/param_right_rotator_pipe_if.sv
// Valid/ready stream bundle: input side (word + amount) and output side.
interface param_right_rotator_pipe_if
  import rotator_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  localparam int unsigned W = word_width(N);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_amt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [N-1:0] out_amt;

  // Producer/consumer side of the rotator.
  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_amt
  );

  // The rotator itself.
  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_amt
  );

endinterface

// File: rtl/param_right_rotator_pipe_stage.sv
// One registered pipeline stage: conditionally rotates right by 2**K when
// amount bit K is set, with valid/ready flow control.
module rotr_stage
  import rotator_pkg::*;
#(
  parameter  int unsigned N = N_DEFAULT,
  parameter  int unsigned K = 0,
  localparam int unsigned W = word_width(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_dat,
  input  logic [N-1:0] up_amt,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_dat,
  output logic [N-1:0] dn_amt
);

  localparam int unsigned R = 1 << K;

  typedef struct packed {
    logic [W-1:0] dat;
    logic [N-1:0] amt;
  } payload_t;

  logic         vld_q, vld_d;
  payload_t     pay_q, pay_d;
  logic         load;
  logic [W-1:0] rot_dat;

  // An empty stage, or one whose word leaves this cycle, can take a new word.
  assign up_ready = !vld_q || dn_ready;
  assign load     = up_valid && up_ready;
  assign rot_dat  = W'(rotr(MAX_W'(up_dat), R, W));

  assign dn_valid = vld_q;
  assign dn_dat   = pay_q.dat;
  assign dn_amt   = pay_q.amt;

  // Next state: load (possibly concurrent with a drain), drain to empty, or hold.
  always_comb begin
    vld_d = vld_q;
    pay_d = pay_q;
    if (load) begin
      vld_d     = 1'b1;
      pay_d.dat = up_amt[K] ? rot_dat : up_dat;
      pay_d.amt = up_amt;
    end else if (dn_ready) begin
      vld_d = 1'b0;
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      pay_q <= '0;
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

endmodule

// File: rtl/param_right_rotator_pipe.sv
// Pipelined barrel rotate-right for 2**N-bit words, one log stage per clock,
// with full valid/ready backpressure. Amount is echoed on out_amt.
module param_right_rotator_pipe
  import rotator_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic                 clk,
  input logic                 reset_n,
  param_right_rotator_pipe_if.slave bus
);

  localparam int unsigned W = word_width(N);

  if (N == 0 || N > MAX_N) begin : g_bad_n
    $error("param_right_rotator_pipe: N out of range");
  end

  // Index k is the upstream side of stage k; index N is the output port.
  logic         vld [N+1];
  logic         rdy [N+1];
  logic [W-1:0] dat [N+1];
  logic [N-1:0] amt [N+1];

  assign vld[0]        = bus.in_valid;
  assign dat[0]        = bus.in_data;
  assign amt[0]        = bus.in_amt;
  assign bus.in_ready  = rdy[0];

  assign rdy[N]        = bus.out_ready;
  assign bus.out_valid = vld[N];
  assign bus.out_data  = dat[N];
  assign bus.out_amt   = amt[N];

  for (genvar k = 0; k < N; k++) begin : g_stage
    rotr_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .up_valid (vld[k]),
      .up_ready (rdy[k]),
      .up_dat   (dat[k]),
      .up_amt   (amt[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_dat   (dat[k+1]),
      .dn_amt   (amt[k+1])
    );
  end

endmodule
